// File: rtl/tjmono_multi_rx_seq_pkg.sv
// Shared types and OUT_DATA field layout for the TJ-Monopix readout sequencer.
package tjmono_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PUSH  = 2'd3
    } state_t;

    // Channel index width; never zero so a single channel still has a field.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // OUT_DATA = {ch, cont, ts, data}, data at bit 0.
    function automatic int out_width(input int ch_w, input int ts_w, input int data_w);
        return ch_w + 1 + ts_w + data_w;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

    function automatic int ts_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cont_bit(input int ts_w, input int data_w);
        return data_w + ts_w;
    endfunction

    function automatic int ch_lsb(input int ts_w, input int data_w);
        return data_w + ts_w + 1;
    endfunction

endpackage

// File: rtl/tjmono_multi_rx_seq_if.sv
// Output word stream: valid/ready handshake carrying one tagged hit per beat.
interface tjmono_multi_rx_seq_if
    import tjmono_rx_pkg::*;
#(
    parameter int OUT_W = out_width(2, 16, 27)
) ();
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [OUT_W-1:0] OUT_DATA;

    modport master (output OUT_VALID, output OUT_DATA, input OUT_READY);
    modport slave  (input OUT_VALID, input OUT_DATA, output OUT_READY);
endinterface

// File: rtl/tjmono_multi_rx_seq_arb.sv
// Round-robin arbiter: first requester strictly after the last grant, wrapping.
module tjmono_rr_arbiter
    import tjmono_rx_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] idx
);

    logic [CH_W-1:0] cand;
    logic            found;

    // Scan last+1 .. last+N_CH (mod N_CH); the old winner is checked last.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(last) + k) % N_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/tjmono_multi_rx_seq.sv
// Multi-channel token/freeze/read sequencer: arbitrates channels, runs the
// counter window, deserialises one hit and emits it as a tagged output word.
module tjmono_multi_rx_seq
    import tjmono_rx_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 27,
    parameter int TS_W   = 16
) (
    input  logic                CLK_BX,
    input  logic                RST_N,
    input  logic                CONF_EN,
    input  logic [CNT_W-1:0]    CONF_START_FREEZE,
    input  logic [CNT_W-1:0]    CONF_START_READ,
    input  logic [CNT_W-1:0]    CONF_STOP_READ,
    input  logic [CNT_W-1:0]    CONF_STOP,
    input  logic [TS_W-1:0]     TIMESTAMP,
    input  logic [N_CH-1:0]     RX_TOKEN,
    input  logic [N_CH-1:0]     RX_DATA,
    output logic [N_CH-1:0]     RX_FREEZE,
    output logic [N_CH-1:0]     RX_READ,
    output logic                BUSY,
    output logic [31:0]         HIT_CNT,
    tjmono_multi_rx_seq_if.master out
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int OUT_W = out_width(CH_W, TS_W, DATA_W);
    localparam int BC_W  = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   tok_meta, tok_s;
    logic [CH_W-1:0]   sel, last, gnt_idx;
    logic [N_CH-1:0]   grant;
    logic [CNT_W-1:0]  cnt;
    logic              cont;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] ser;
    logic [BC_W-1:0]   bit_cnt;
    logic              start, out_free, push_load;
    logic [N_CH-1:0]   read_d;
    logic [OUT_W-1:0]  out_word;

    tjmono_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req   (tok_s),
        .last  (last),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign BUSY     = (state_q != ST_IDLE);
    assign out_free = !out.OUT_VALID || out.OUT_READY;

    // Two-flop synchroniser on the asynchronous token pins.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N) begin
            tok_meta <= '0;
            tok_s    <= '0;
        end else begin
            tok_meta <= RX_TOKEN;
            tok_s    <= tok_meta;
        end
    end

    // State register.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; PUSH only leaves once the word has a place in the output register.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        push_load = 1'b0;
        case (state_q)
            ST_IDLE:  if (CONF_EN && |grant) begin
                          start   = 1'b1;
                          state_d = ST_RUN;
                      end
            ST_RUN:   if (cnt == CONF_STOP) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == '0) state_d = ST_PUSH;
            ST_PUSH:  if (out_free) begin
                          push_load = 1'b1;
                          state_d   = tok_s[sel] ? ST_RUN : ST_IDLE;
                      end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Burst datapath. The MSB is sampled on the RUN exit edge, so SHIFT only
    // needs DATA_W-1 more cycles and the LSB lands STOP+DATA_W after RUN start.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N) begin
            sel     <= '0;
            last    <= CH_W'(N_CH - 1);
            cnt     <= '0;
            cont    <= 1'b0;
            ts      <= '0;
            ser     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    sel  <= gnt_idx;
                    ts   <= TIMESTAMP;
                    cont <= 1'b0;
                    cnt  <= '0;
                end
                ST_RUN: begin
                    if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
                    if (cnt == CONF_STOP) begin
                        ser     <= {ser[DATA_W-2:0], RX_DATA[sel]};
                        bit_cnt <= BC_W'(DATA_W - 2);
                    end
                end
                ST_SHIFT: begin
                    ser <= {ser[DATA_W-2:0], RX_DATA[sel]};
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                end
                ST_PUSH: if (push_load) begin
                    if (tok_s[sel]) begin
                        cnt  <= '0;
                        cont <= 1'b1;
                        ts   <= TIMESTAMP;
                    end else begin
                        last <= sel;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read strobe window for the served channel only.
    always_comb begin
        read_d = '0;
        if (state_q == ST_RUN && cnt >= CONF_START_READ && cnt < CONF_STOP_READ)
            read_d[sel] = 1'b1;
    end

    // Freeze rises once per burst (not on continuations) and drops only when
    // the sequencer releases the channel back to IDLE.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N) begin
            RX_FREEZE <= '0;
            RX_READ   <= '0;
        end else begin
            RX_READ <= read_d;
            if (push_load && !tok_s[sel])
                RX_FREEZE <= '0;
            else if (state_q == ST_RUN && cnt == CONF_START_FREEZE && !cont)
                RX_FREEZE[sel] <= 1'b1;
        end
    end

    // Pack the outgoing word from the package field offsets.
    always_comb begin
        out_word                             = '0;
        out_word[data_lsb() +: DATA_W]       = ser;
        out_word[ts_lsb(DATA_W) +: TS_W]     = ts;
        out_word[cont_bit(TS_W, DATA_W)]     = cont;
        out_word[ch_lsb(TS_W, DATA_W) +: CH_W] = sel;
    end

    // Output register: reload in the same cycle the old word is taken.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N) begin
            out.OUT_VALID <= 1'b0;
            out.OUT_DATA  <= '0;
        end else if (push_load) begin
            out.OUT_VALID <= 1'b1;
            out.OUT_DATA  <= out_word;
        end else if (out.OUT_READY) begin
            out.OUT_VALID <= 1'b0;
        end
    end

    // Accepted-word counter, free-running with wrap.
    always_ff @(posedge CLK_BX or negedge RST_N) begin
        if (!RST_N)                              HIT_CNT <= '0;
        else if (out.OUT_VALID && out.OUT_READY) HIT_CNT <= HIT_CNT + 32'd1;
    end

endmodule

// File: tb/tb_tjmono_multi_rx_seq.sv
// Directed bench for tjmono_multi_rx_seq: vector table of single hits plus
// hand-written continuation, round-robin, backpressure and reset sequences.
module tb_tjmono_multi_rx_seq;

    localparam int OUT_W = 46;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        conf_en = 1'b1;
    logic [7:0]  cfg_sf = 8'd2, cfg_sr = 8'd6, cfg_str = 8'd7, cfg_stop = 8'd10;
    logic [15:0] ts_val = 16'h1000;
    logic [3:0]  rx_tok = '0, rx_data = '0;
    logic [3:0]  rx_freeze, rx_read;
    logic        busy;
    logic [31:0] hit_cnt;

    tjmono_multi_rx_seq_if #(.OUT_W(OUT_W)) o ();

    tjmono_multi_rx_seq #(.N_CH(4), .CNT_W(8), .DATA_W(27), .TS_W(16)) dut (
        .CLK_BX(clk), .RST_N(rst_n), .CONF_EN(conf_en),
        .CONF_START_FREEZE(cfg_sf), .CONF_START_READ(cfg_sr),
        .CONF_STOP_READ(cfg_str), .CONF_STOP(cfg_stop),
        .TIMESTAMP(ts_val), .RX_TOKEN(rx_tok), .RX_DATA(rx_data),
        .RX_FREEZE(rx_freeze), .RX_READ(rx_read), .BUSY(busy),
        .HIT_CNT(hit_cnt), .out(o)
    );

    always #5 clk = ~clk;

    // Free-running timestamp, changed well clear of the sampling edge.
    always @(posedge clk) begin
        #2;
        ts_val = ts_val + 16'd1;
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected words in arrival order.
    typedef struct {
        logic [1:0]  ch;
        logic        cont;
        logic [15:0] ts;
        logic        ts_chk;
        logic [26:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Output monitor: every handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && o.OUT_VALID && o.OUT_READY) begin
            if (sb.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL extra_word: actual %0h expected no word", o.OUT_DATA);
            end else begin
                mon_e = sb.pop_front();
                chk("word_ch",   64'(o.OUT_DATA[45:44]), 64'(mon_e.ch));
                chk("word_cont", 64'(o.OUT_DATA[43]),    64'(mon_e.cont));
                chk("word_data", 64'(o.OUT_DATA[26:0]),  64'(mon_e.data));
                if (mon_e.ts_chk)
                    chk("word_ts", 64'(o.OUT_DATA[42:27]), 64'(mon_e.ts));
            end
        end
    end

    // Chip model: a read pops the next hit; its bits follow MSB first so the
    // MSB is on the pin for the edge STOP+1 after RUN start; token = hits left.
    logic [26:0] cmem [4][8];
    logic [26:0] cur  [4];
    int          cwr  [4] = '{default: 0};
    int          crd  [4] = '{default: 0};
    int          kc   [4] = '{default: 100};

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (rx_read[c]) begin
                cur[c] = cmem[c][crd[c] % 8];
                crd[c] = crd[c] + 1;
                kc[c]  = 0;
            end else if (kc[c] < 100) begin
                kc[c] = kc[c] + 1;
            end
            if (kc[c] >= 3 && kc[c] < 30) rx_data[c] = cur[c][5'(29 - kc[c])];
            else                          rx_data[c] = 1'b0;
            rx_tok[c] = (cwr[c] != crd[c]);
        end
    end

    task automatic add_hit(input int ch, input logic [26:0] w);
        cmem[ch][cwr[ch] % 8] = w;
        cwr[ch] = cwr[ch] + 1;
    endtask

    task automatic push_exp(input int ch, input logic cont, input logic [15:0] ts,
                            input logic ts_chk, input logic [26:0] w);
        exp_t e;
        e.ch = 2'(ch); e.cont = cont; e.ts = ts; e.ts_chk = ts_chk; e.data = w;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int c = 0;
        while ((sb.size() != 0 || busy || o.OUT_VALID) && c < maxc) begin
            tick();
            c++;
        end
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({name, "_idle"},     64'(busy),      64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Single-hit vectors: channel, serial word, and hand-timed expectations
    // in edges after the token (STOP=10, DATA_W=27, window 2/6/7).
    typedef struct {
        int          ch;
        logic [26:0] word;
        int          lat;
        int          rd_first;
        int          frz_first;
    } vec_t;
    vec_t tbl[4];

    task automatic run_vec(input vec_t v);
        int          n, rd_first, rd_cnt, frz_first;
        logic        frz40, frz41, got;
        logic [3:0]  others;
        logic [15:0] t0;
        @(posedge clk); #3;
        t0 = ts_val;
        push_exp(v.ch, 1'b0, t0 + 16'd2, 1'b1, v.word);
        add_hit(v.ch, v.word);
        n = 0; rd_first = 0; rd_cnt = 0; frz_first = 0;
        frz40 = 1'b0; frz41 = 1'b1; got = 1'b0; others = '0;
        while (n < 200 && !got) begin
            tick();
            n++;
            if (rx_read[v.ch]) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = n - 1;
            end
            if (rx_freeze[v.ch] && frz_first == 0) frz_first = n - 1;
            if (n == 40) frz40 = rx_freeze[v.ch];
            if (n == 41) frz41 = rx_freeze[v.ch];
            others |= (rx_read | rx_freeze) & ~(4'b0001 << v.ch);
            if (o.OUT_VALID) got = 1'b1;
        end
        chk("vec_latency",     64'(n - 1),     64'(v.lat));
        chk("vec_read_first",  64'(rd_first),  64'(v.rd_first));
        chk("vec_read_cycles", 64'(rd_cnt),    64'd1);
        chk("vec_freeze_rise", 64'(frz_first), 64'(v.frz_first));
        chk("vec_freeze_held", 64'(frz40),     64'd1);
        chk("vec_freeze_drop", 64'(frz41),     64'd0);
        chk("vec_other_ch",    64'(others),    64'd0);
        wait_drain("vec", 20);
    endtask

    initial begin
        int          n, gap;
        logic        frz79, val79;
        logic [15:0] t0;

        tbl[0] = '{ch: 2, word: 27'h5A5A5A5, lat: 40, rd_first: 9, frz_first: 5};
        tbl[1] = '{ch: 0, word: 27'h7FFFFFF, lat: 40, rd_first: 9, frz_first: 5};
        tbl[2] = '{ch: 3, word: 27'h4000001, lat: 40, rd_first: 9, frz_first: 5};
        tbl[3] = '{ch: 1, word: 27'h1234567, lat: 40, rd_first: 9, frz_first: 5};

        o.OUT_READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  64'(o.OUT_VALID), 64'd0);
        chk("rst_data",   64'(o.OUT_DATA),  64'd0);
        chk("rst_freeze", 64'(rx_freeze),   64'd0);
        chk("rst_read",   64'(rx_read),     64'd0);
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_hitcnt", 64'(hit_cnt),     64'd0);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);
        chk("vec_hitcnt", 64'(hit_cnt), 64'd4);

        // Continuation: two hits queued on ch1 keep the token up through the first PUSH.
        @(posedge clk); #3;
        t0 = ts_val;
        push_exp(1, 1'b0, t0 + 16'd2,  1'b1, 27'h0F0F0F0);
        push_exp(1, 1'b1, t0 + 16'd40, 1'b1, 27'h3C3C3C3);
        add_hit(1, 27'h0F0F0F0);
        add_hit(1, 27'h3C3C3C3);
        gap = 0; frz79 = 1'b1; val79 = 1'b0;
        for (n = 1; n <= 79; n++) begin
            tick();
            if (n >= 6 && n <= 78 && !rx_freeze[1]) gap++;
            if (n == 79) begin
                frz79 = rx_freeze[1];
                val79 = o.OUT_VALID;
            end
        end
        chk("cont_freeze_gap",  64'(gap),   64'd0);
        chk("cont_freeze_drop", 64'(frz79), 64'd0);
        chk("cont_second_word", 64'(val79), 64'd1);
        wait_drain("cont", 40);

        // Round-robin after reset: ch0 and ch3 together, then ch0 again -> 0, 3, 0.
        pulse_reset();
        @(posedge clk); #3;
        push_exp(0, 1'b0, 16'h0, 1'b0, 27'h0000AAA);
        push_exp(3, 1'b0, 16'h0, 1'b0, 27'h3333333);
        push_exp(0, 1'b0, 16'h0, 1'b0, 27'h5555000);
        add_hit(0, 27'h0000AAA);
        add_hit(3, 27'h3333333);
        n = 0;
        while (sb.size() > 2 && n < 200) begin
            tick();
            n++;
        end
        chk("rr_first_out", 64'(sb.size()), 64'd2);
        #2;
        add_hit(0, 27'h5555000);
        wait_drain("rr", 300);
        chk("rr_hitcnt", 64'(hit_cnt), 64'd3);

        // Backpressure: two hits with the sink stalled for 100 cycles.
        pulse_reset();
        @(posedge clk); #3;
        o.OUT_READY = 1'b0;
        push_exp(1, 1'b0, 16'h0, 1'b0, 27'h1111111);
        push_exp(2, 1'b0, 16'h0, 1'b0, 27'h2222222);
        add_hit(1, 27'h1111111);
        add_hit(2, 27'h2222222);
        repeat (100) tick();
        chk("bp_busy",    64'(busy),                64'd1);
        chk("bp_freeze",  64'(rx_freeze),           64'h4);
        chk("bp_valid",   64'(o.OUT_VALID),         64'd1);
        chk("bp_head_ch", 64'(o.OUT_DATA[45:44]),   64'd1);
        chk("bp_pending", 64'(sb.size()),           64'd2);
        chk("bp_hitcnt0", 64'(hit_cnt),             64'd0);
        #2;
        o.OUT_READY = 1'b1;
        tick();
        tick();
        chk("bp_drained", 64'(sb.size()),   64'd0);
        chk("bp_valid0",  64'(o.OUT_VALID), 64'd0);
        chk("bp_hitcnt",  64'(hit_cnt),     64'd2);
        chk("bp_freeze0", 64'(rx_freeze),   64'd0);
        chk("bp_idle",    64'(busy),        64'd0);

        // Asynchronous reset in the middle of SHIFT on ch1.
        @(posedge clk); #3;
        add_hit(1, 27'h2AAAAAA);
        repeat (20) tick();
        chk("ar_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid",  64'(o.OUT_VALID), 64'd0);
        chk("ar_data",   64'(o.OUT_DATA),  64'd0);
        chk("ar_freeze", 64'(rx_freeze),   64'd0);
        chk("ar_read",   64'(rx_read),     64'd0);
        chk("ar_busy",   64'(busy),        64'd0);
        chk("ar_hitcnt", 64'(hit_cnt),     64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #3;
        push_exp(0, 1'b0, 16'h0, 1'b0, 27'h0ABCDEF);
        push_exp(2, 1'b0, 16'h0, 1'b0, 27'h6543210);
        add_hit(2, 27'h6543210);
        add_hit(0, 27'h0ABCDEF);
        wait_drain("ar", 300);
        chk("ar_hitcnt_after", 64'(hit_cnt), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
